// File: rtl/imem_arbiter_if.sv
// Requester-side and memory-side signal bundle for imem_arbiter.
// slave = arbiter side, master = requesters plus memory.
`ifndef IMEM_BLOCK_ADDR_SIZE
`define IMEM_BLOCK_ADDR_SIZE 16
`endif
`ifndef IBLOCK_SIZE_BITS
`define IBLOCK_SIZE_BITS 128
`endif

interface imem_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = `IMEM_BLOCK_ADDR_SIZE,
  parameter int DATA_W = `IBLOCK_SIZE_BITS
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]       resp_data;
  logic                    mem_ren;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_ready;
  logic [DATA_W-1:0]       mem_dout;

  modport slave (
    input  req, req_addr, mem_ready, mem_dout,
    output resp_valid, resp_data, mem_ren, mem_addr
  );

  modport master (
    output req, req_addr, mem_ready, mem_dout,
    input  resp_valid, resp_data, mem_ren, mem_addr
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction memory among N_REQ block readers.
// Sequence per access: IDLE (grant) -> BUSY (ren until ready/timeout) -> DONE (resp pulse).
`ifndef IMEM_BLOCK_ADDR_SIZE
`define IMEM_BLOCK_ADDR_SIZE 16
`endif
`ifndef IBLOCK_SIZE_BITS
`define IBLOCK_SIZE_BITS 128
`endif

module imem_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = `IMEM_BLOCK_ADDR_SIZE,
  parameter int DATA_W  = `IBLOCK_SIZE_BITS,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  imem_arbiter_if.slave bus,
  output logic          busy,
  output logic          timeout_err
);
  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]  next_ptr, sel;
  logic              found;
  logic [7:0]        tcnt_q, tcnt_d;
  logic              mem_ren_q, mem_ren_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              busy_q, busy_d;
  logic              terr_q, terr_d;
  logic [ADDR_W-1:0] addr_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_a[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
  end

  // First requester at or above rr_ptr, wrapping past the top index.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx -= N_REQ;
      if (!found && bus.req[PTR_W'(idx)]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  assign next_ptr = (gnt_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    tcnt_d       = tcnt_q;
    mem_ren_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    busy_d       = busy_q;
    terr_d       = terr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_BUSY;
          gnt_d      = sel;
          mem_addr_d = addr_a[sel];
          tcnt_d     = '0;
          mem_ren_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_BUSY: begin
        tcnt_d = tcnt_q + 8'd1;
        if (bus.mem_ready) begin
          // Ready wins over a coincident timeout.
          resp_data_d         = bus.mem_dout;
          resp_valid_d[gnt_q] = 1'b1;
          state_d             = S_DONE;
        end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
          terr_d   = 1'b1;
          rr_ptr_d = next_ptr;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          mem_ren_d = 1'b1;
        end
      end
      S_DONE: begin
        rr_ptr_d = next_ptr;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      tcnt_q       <= '0;
      mem_ren_q    <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      tcnt_q       <= tcnt_d;
      mem_ren_q    <= mem_ren_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
    end
  end

  assign bus.mem_ren    = mem_ren_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = busy_q;
  assign timeout_err    = terr_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios then randomized traffic,
// compared against a transaction-level round-robin / latency model.
module tb_imem_arbiter;
  localparam int N_REQ   = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy, timeout_err;

  imem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: ready after `lat` consecutive ren cycles; lat==0 never readies.
  int lat = 4;
  int ren_cnt = 0;

  function automatic logic [DATA_W-1:0] block_of(input logic [ADDR_W-1:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  always @(posedge clock) ren_cnt <= bus.mem_ren ? ren_cnt + 1 : 0;
  assign bus.mem_ready = bus.mem_ren && (lat != 0) && (ren_cnt == lat - 1);
  assign bus.mem_dout  = bus.mem_ready ? block_of(bus.mem_addr) : 32'hBAD0_BAD0;

  // Reference state
  int                m_ptr  = 0;
  int                m_gap  = 0;
  logic              m_terr = 1'b0;
  logic [DATA_W-1:0] m_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.req   = '0;
    @(negedge clock);
    @(negedge clock);
    reset     = 1'b0;
    m_ptr  = 0;
    m_gap  = 0;
    m_terr = 1'b0;
    m_data = '0;
    check("rst_ren",   64'(bus.mem_ren), 64'(0));
    check("rst_addr",  64'(bus.mem_addr), 64'(0));
    check("rst_rv",    64'(bus.resp_valid), 64'(0));
    check("rst_data",  64'(bus.resp_data), 64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_terr",  64'(timeout_err), 64'(0));
  endtask

  // Issue request pattern r at a negedge where the arbiter is in DONE or IDLE,
  // then follow the access to completion or timeout.
  task automatic txn(input logic [N_REQ-1:0] r, input logic [ADDR_W-1:0] a0,
                     input logic [ADDR_W-1:0] a1, input int l, input bit perturb);
    logic [ADDR_W-1:0] addrs [N_REQ];
    logic [ADDR_W-1:0] ea;
    int g, n, exp_len;
    bit ok;
    addrs[0] = a0;
    addrs[1] = a1;
    bus.req      = r;
    bus.req_addr = {a1, a0};
    lat          = l;

    g = -1;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % N_REQ;
      if (g < 0 && ((int'(r) >> idx) & 1) == 1) g = idx;
    end
    ea      = addrs[g];
    ok      = (l >= 1) && (l <= TIMEOUT);
    exp_len = ok ? l : TIMEOUT;

    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.mem_ren) break;
      check("idle_rv", 64'(bus.resp_valid), 64'(0));
      n++;
    end
    check("gap", 64'(n), 64'(m_gap));
    check("addr", 64'(bus.mem_addr), 64'(ea));
    check("busy_on", 64'(busy), 64'(1));

    n = 0;
    while (bus.mem_ren && n < TIMEOUT + 4) begin
      check("busy_rv", 64'(bus.resp_valid), 64'(0));
      n++;
      if (perturb) begin
        bus.req      = N_REQ'($urandom);
        bus.req_addr = (N_REQ*ADDR_W)'($urandom);
      end
      @(negedge clock);
    end
    check("ren_len", 64'(n), 64'(exp_len));

    m_ptr = (g + 1) % N_REQ;
    if (ok) begin
      m_data = block_of(ea);
      m_gap  = 1;
      check("rv", 64'(bus.resp_valid), 64'(1) << g);
      check("busy_done", 64'(busy), 64'(1));
    end else begin
      m_terr = 1'b1;
      m_gap  = 0;
      check("rv_to", 64'(bus.resp_valid), 64'(0));
      check("busy_to", 64'(busy), 64'(0));
    end
    check("data", 64'(bus.resp_data), 64'(m_data));
    check("terr", 64'(timeout_err), 64'(m_terr));
  endtask

  initial begin
    bus.req      = '0;
    bus.req_addr = '0;

    // 1: single requester, latency 4
    do_reset();
    txn(2'b01, 8'h10, 8'h00, 4, 1'b0);

    // 2: both held, alternation 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) txn(2'b11, 8'h03, 8'h07, 3, 1'b0);

    // 3: only requester 1 after reset, then both
    do_reset();
    txn(2'b10, 8'h21, 8'h42, 2, 1'b0);
    txn(2'b11, 8'h21, 8'h42, 5, 1'b0);

    // 4: memory never ready, then a normal access with sticky error
    txn(2'b01, 8'h55, 8'h66, 0, 1'b0);
    txn(2'b11, 8'h55, 8'h66, 1, 1'b0);

    // 5: reset in the second BUSY cycle
    bus.req      = 2'b01;
    bus.req_addr = {8'h99, 8'h88};
    lat          = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.mem_ren) break;
    end
    check("mid_ren_on", 64'(bus.mem_ren), 64'(1));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_ren",  64'(bus.mem_ren), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_rv",   64'(bus.resp_valid), 64'(0));
    check("mid_terr", 64'(timeout_err), 64'(0));
    check("mid_data", 64'(bus.resp_data), 64'(0));
    m_ptr  = 0;
    m_gap  = 0;
    m_terr = 1'b0;
    m_data = '0;
    txn(2'b10, 8'h88, 8'h99, 3, 1'b0);

    // 6: ready coincides with the final timeout cycle
    txn(2'b01, 8'h22, 8'h33, TIMEOUT, 1'b0);

    // Randomized traffic with request/address churn during BUSY
    for (int i = 0; i < 40; i++) begin
      txn(N_REQ'($urandom_range(1, 3)), ADDR_W'($urandom), ADDR_W'($urandom),
          int'($urandom_range(0, TIMEOUT + 2)), 1'($urandom_range(0, 1)));
    end

    bus.req = '0;
    repeat (3) @(negedge clock);
    check("end_rv", 64'(bus.resp_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
